// File: rtl/lab3_mem_line_mem_responder_pkg.sv
// lab3_mem_line_mem_responder_pkg: shared 16B memory message types and type_ encodings.
package lab3_mem_line_mem_responder_pkg;

    localparam logic [3:0] MEM_READ  = 4'd0;
    localparam logic [3:0] MEM_WRITE = 4'd1;
    localparam logic [3:0] MEM_INIT  = 4'd2;

    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    // Init behaves exactly like write; every other unknown encoding is a read.
    function automatic logic is_store(logic [3:0] t);
        return t == MEM_WRITE || t == MEM_INIT;
    endfunction

endpackage

// File: rtl/lab3_mem_line_mem_responder_if.sv
// lab3_mem_line_mem_responder_if: val/rdy request and response channels of the line memory.
interface lab3_mem_line_mem_responder_if;
    import lab3_mem_line_mem_responder_pkg::*;

    logic          memreq_val;
    logic          memreq_rdy;
    mem_req_16B_t  memreq_msg;
    logic          memresp_val;
    logic          memresp_rdy;
    mem_resp_16B_t memresp_msg;

    modport master (
        output memreq_val, memreq_msg, memresp_rdy,
        input  memreq_rdy, memresp_val, memresp_msg
    );

    modport slave (
        input  memreq_val, memreq_msg, memresp_rdy,
        output memreq_rdy, memresp_val, memresp_msg
    );

endinterface

// File: rtl/lab3_mem_line_mem_responder_sram.sv
// vc_CombinationalSRAM_1rw: combinational-read, clocked byte-enabled write storage array.
module vc_CombinationalSRAM_1rw #(
    parameter  int p_data_nbits  = 128,
    parameter  int p_num_entries = 64,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_nbytes      = (p_data_nbits + 7) / 8
) (
    input  logic                    clk,
    input  logic                    read_en,
    input  logic [c_addr_nbits-1:0] read_addr,
    output logic [p_data_nbits-1:0] read_data,
    input  logic                    write_en,
    input  logic [c_nbytes-1:0]     write_byte_en,
    input  logic [c_addr_nbits-1:0] write_addr,
    input  logic [p_data_nbits-1:0] write_data
);

    logic [p_data_nbits-1:0] mem [p_num_entries];

    assign read_data = read_en ? mem[read_addr] : '0;

    always_ff @(posedge clk)
        if (write_en)
            for (int i = 0; i < c_nbytes; i++)
                if (write_byte_en[i])
                    mem[write_addr][i*8 +: 8] <= write_data[i*8 +: 8];

endmodule

// File: rtl/lab3_mem_line_mem_responder.sv
// lab3_mem_line_mem_responder: single-outstanding line memory with fixed response latency.
module lab3_mem_line_mem_responder
    import lab3_mem_line_mem_responder_pkg::*;
#(
    parameter int p_latency   = 2,
    parameter int p_num_lines = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    lab3_mem_line_mem_responder_if.slave    mem,
    output logic [31:0]                     num_reqs
);

    localparam int lw = $clog2(p_num_lines);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   num_q;
    mem_resp_16B_t resp_q;
    logic          acc;
    logic          wr;
    logic [lw-1:0] idx;
    logic [127:0]  rd_data;
    logic          unused;

    assign mem.memreq_rdy  = state_q == IDLE && !reset;
    assign mem.memresp_val = state_q == RESP;
    assign mem.memresp_msg = resp_q;
    assign num_reqs        = num_q;

    assign acc    = mem.memreq_val && mem.memreq_rdy;
    assign wr     = acc && is_store(mem.memreq_msg.type_);
    assign idx    = mem.memreq_msg.addr[4 +: lw];
    assign unused = ^{mem.memreq_msg.len, mem.memreq_msg.addr};

    vc_CombinationalSRAM_1rw #(
        .p_data_nbits  (128),
        .p_num_entries (p_num_lines)
    ) u_sram (
        .clk           (clk),
        .read_en       (acc),
        .read_addr     (idx),
        .read_data     (rd_data),
        .write_en      (wr),
        .write_byte_en ('1),
        .write_addr    (idx),
        .write_data    (mem.memreq_msg.data)
    );

    // The whole response is captured at accept so it stays stable through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            resp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    resp_q  <= '{type_:  mem.memreq_msg.type_,
                                 opaque: mem.memreq_msg.opaque,
                                 test:   2'b0,
                                 len:    4'b0,
                                 data:   wr ? 128'b0 : rd_data};
                    cnt_q   <= 4'(p_latency);
                    state_q <= p_latency == 0 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q   <= cnt_q - 4'd1;
                    state_q <= cnt_q == 4'd1 ? RESP : WAIT;
                end
                RESP: if (mem.memresp_rdy) begin
                    state_q <= IDLE;
                    num_q   <= num_q + 32'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// tb_lab3_mem_line_mem_responder: vector table, random model-checked traffic and corner sequences.
module tb_lab3_mem_line_mem_responder;
    import lab3_mem_line_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] na, nb;
    int          n_cmp = 0, n_bad = 0, exp_num = 0;

    logic [127:0] model [64];
    bit           written [64];

    lab3_mem_line_mem_responder_if ia ();
    lab3_mem_line_mem_responder_if ib ();

    lab3_mem_line_mem_responder #(.p_latency(2), .p_num_lines(64)) dut_a (
        .clk(clk), .reset(reset), .mem(ia), .num_reqs(na));

    lab3_mem_line_mem_responder #(.p_latency(0), .p_num_lines(64)) dut_b (
        .clk(clk), .reset(reset), .mem(ib), .num_reqs(nb));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]   t;
        logic [7:0]   op;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    localparam logic [127:0] D1 = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] D2 = 128'hdeadbeef_00000000_11111111_22222222;
    localparam logic [127:0] D3 = 128'hcafef00d_33333333_44444444_55555555;
    localparam logic [127:0] D4 = 128'h0badc0de_66666666_77777777_88888888;
    localparam logic [127:0] D5 = 128'hfeedface_99999999_aaaaaaaa_bbbbbbbb;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int line_of(logic [31:0] a);
        return int'((a / 16) % 64);
    endfunction

    function automatic logic stores(logic [3:0] t);
        return t == 4'd1 || t == 4'd2;
    endfunction

    task automatic txn(input logic [3:0] t, input logic [7:0] op, input logic [31:0] addr,
                       input logic [127:0] data, input logic [127:0] exp_data, input int hold);
        int k;
        mem_resp_16B_t e;
        e = '{type_: t, opaque: op, test: 2'b0, len: 4'b0, data: exp_data};
        @(negedge clk);
        ia.memresp_rdy = 1'b0;
        ia.memreq_val  = 1'b1;
        ia.memreq_msg  = '{type_: t, opaque: op, addr: addr, len: 4'($urandom), data: data};
        k = 0;
        while (!ia.memreq_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ia.memreq_rdy) chk("req_rdy_timeout", 0, 1);
        @(posedge clk);
        #1 ia.memreq_val = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ia.memresp_val && k < 20);
        chk("latency", k, 3);
        chk("req_rdy_in_resp", ia.memreq_rdy, 0);
        chk("resp_msg", ia.memresp_msg, e);
        chk("resp_data", ia.memresp_msg.data, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_val", ia.memresp_val, 1);
            chk("hold_msg", ia.memresp_msg, e);
            chk("hold_req_rdy", ia.memreq_rdy, 0);
            chk("hold_num", na, exp_num);
        end
        ia.memresp_rdy = 1'b1;
        @(posedge clk);
        #1 ia.memresp_rdy = 1'b0;
        exp_num++;
        @(negedge clk);
        chk("num_reqs", na, exp_num);
        chk("val_after_hs", ia.memresp_val, 0);
        chk("req_rdy_after_hs", ia.memreq_rdy, 1);
        if (stores(t)) begin
            model[line_of(addr)]   = data;
            written[line_of(addr)] = 1'b1;
        end
    endtask

    vec_t tbl [7];

    initial begin
        int r, ln;
        logic [3:0]   t;
        logic [31:0]  a;
        logic [127:0] d;

        tbl[0] = '{4'd2, 8'h01, 32'h0000_0100, D1, 128'h0, 0};
        tbl[1] = '{4'd0, 8'h05, 32'h0000_0100, 128'h0, D1, 0};
        tbl[2] = '{4'd1, 8'h22, 32'h0000_0000, D2, 128'h0, 5};
        tbl[3] = '{4'd1, 8'h23, 32'h0000_0400, D3, 128'h0, 0};
        tbl[4] = '{4'd0, 8'h24, 32'h0000_0000, 128'h0, D3, 1};
        tbl[5] = '{4'd7, 8'h25, 32'h0000_010f, D2, D1, 2};
        tbl[6] = '{4'd0, 8'hff, 32'hffff_f10c, 128'h0, D1, 0};

        reset = 1'b1;
        ia.memreq_val = 1'b0; ia.memresp_rdy = 1'b0; ia.memreq_msg = '0;
        ib.memreq_val = 1'b0; ib.memresp_rdy = 1'b0; ib.memreq_msg = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", ia.memreq_rdy, 0);
        chk("rst_resp_val", ia.memresp_val, 0);
        chk("rst_num", na, 0);
        chk("rst_msg", ia.memresp_msg, 0);
        chk("rst_b_req_rdy", ib.memreq_rdy, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_req_rdy", ia.memreq_rdy, 1);

        foreach (tbl[i])
            txn(tbl[i].t, tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].exp, tbl[i].hold);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            t = r == 2 ? 4'd1 : r == 3 ? 4'd2 : r == 4 ? 4'($urandom_range(3, 15)) : 4'd0;
            a = $urandom;
            ln = line_of(a);
            if (!stores(t) && !written[ln]) t = 4'd1;
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(t, 8'($urandom), a, d, stores(t) ? 128'h0 : model[ln], $urandom_range(0, 3));
        end

        // Reset during WAIT drops the response but keeps the accepted write.
        @(negedge clk);
        ia.memreq_val = 1'b1;
        ia.memreq_msg = '{type_: 4'd1, opaque: 8'h44, addr: 32'h0000_0230, len: 4'h0, data: D4};
        @(posedge clk);
        #1 ia.memreq_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_resp_val", ia.memresp_val, 0);
        chk("midrst_num", na, 0);
        chk("midrst_req_rdy", ia.memreq_rdy, 0);
        chk("midrst_msg", ia.memresp_msg, 0);
        exp_num = 0;
        model[line_of(32'h230)]   = D4;
        written[line_of(32'h230)] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_req_rdy", ia.memreq_rdy, 1);
        chk("postrst_resp_val", ia.memresp_val, 0);
        txn(4'd0, 8'h45, 32'h0000_0230, 128'h0, D4, 0);

        // Zero-latency instance: write then read back-to-back.
        @(negedge clk);
        ib.memresp_rdy = 1'b1;
        ib.memreq_val  = 1'b1;
        ib.memreq_msg  = '{type_: 4'd1, opaque: 8'h31, addr: 32'h0000_0050, len: 4'h0, data: D5};
        @(posedge clk);
        #1 ib.memreq_msg = '{type_: 4'd0, opaque: 8'h32, addr: 32'h0000_0050, len: 4'h0, data: 128'h0};
        @(negedge clk);
        chk("b_wr_val", ib.memresp_val, 1);
        chk("b_wr_type", ib.memresp_msg.type_, 1);
        chk("b_wr_data", ib.memresp_msg.data, 0);
        chk("b_busy_req_rdy", ib.memreq_rdy, 0);
        @(negedge clk);
        chk("b_gap_val", ib.memresp_val, 0);
        chk("b_gap_req_rdy", ib.memreq_rdy, 1);
        chk("b_num1", nb, 1);
        @(posedge clk);
        #1 ib.memreq_val = 1'b0;
        @(negedge clk);
        chk("b_rd_val", ib.memresp_val, 1);
        chk("b_rd_msg", ib.memresp_msg, {4'd0, 8'h32, 2'b0, 4'b0, D5});
        @(negedge clk);
        chk("b_num2", nb, 2);
        chk("b_end_val", ib.memresp_val, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lab3_mem_line_mem_responder.md
LAB3_MEM_LINE_MEM_RESPONDER -- requirements
Module: lab3_mem_line_mem_responder

Interface
REQ-001 SHALL have parameter p_latency, default 2, meaning wait cycles inserted between request accept and response valid (legal 0..15).
REQ-002 SHALL have parameter p_num_lines, default 64, meaning number of 16B lines stored (power of two).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port memreq_val  input  1  request valid.
REQ-006 SHALL have port memreq_rdy  output  1  request ready.
REQ-007 SHALL have port memreq_msg  input  mem_req_16B_t  type_, opaque, addr, len, data.
REQ-008 SHALL have port memresp_val  output  1  response valid.
REQ-009 SHALL have port memresp_rdy  input  1  response ready.
REQ-010 SHALL have port memresp_msg  output  mem_resp_16B_t  type_, opaque, test, len, data.
REQ-011 SHALL have port num_reqs  output  32  count of completed response handshakes.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, WAIT, RESP; one outstanding request maximum.
REQ-013 SHALL assert memreq_rdy only in IDLE; memresp_val only in RESP.
REQ-014 IDLE: on memreq_val&memreq_rdy, latch type_, opaque and addr; go to WAIT with counter=p_latency, or directly to RESP if p_latency==0.
REQ-015 WAIT: decrement counter each cycle; go to RESP on the cycle the counter reaches 1.
REQ-016 Response latency SHALL be exactly p_latency+1 cycles: request accepted at edge N -> memresp_val high in the cycle after edge N+p_latency.
REQ-017 RESP: hold memresp_val and a stable memresp_msg until memresp_rdy; on the handshake edge go to IDLE and increment num_reqs (wraps modulo 2^32).
REQ-018 Line index SHALL be addr[3+log2(p_num_lines):4]; higher address bits ignored (aliasing); addr[3:0] ignored.
REQ-019 Write (type_=1): store the full 128-bit data into the line at the accept edge; response data=0.
REQ-020 Init (type_=2): identical to write, response type_=2.
REQ-021 Read (type_=0): response data=line contents sampled at the accept edge.
REQ-022 Any other type_ SHALL be treated as read.
REQ-023 Response fields: type_=latched type_, opaque=latched opaque, test=0, len=0.
REQ-024 len SHALL be ignored; all accesses are full-line.
REQ-025 A new request SHALL NOT be accepted on the same edge as the response handshake; earliest next accept is the following cycle.

Reset
REQ-026 While reset is high: state=IDLE, counter=0, num_reqs=0, memreq_rdy=0, memresp_val=0, memresp_msg=0.
REQ-027 Reset asserted mid-transaction (WAIT or RESP) SHALL discard the pending response; any write already accepted SHALL remain stored.
REQ-028 Line storage SHALL NOT be reset; contents are undefined until written or initialized.

Structure
REQ-029 mem_req_16B_t and mem_resp_16B_t and the type_ encodings SHALL come from the shared memory-message package; FSM state encoding stays local.
REQ-030 Line storage SHALL be a single instance of vc_CombinationalSRAM_1rw (128-bit, p_num_lines entries, byte enables all ones).

Verification
REQ-031 Init addr 0x100 data 0x0123...cdef, then read 0x100 opaque 0x05 -> read response opaque 0x05, data 0x0123...cdef, test 0.
REQ-032 p_latency=2, memresp_rdy=1: read accepted at edge N -> memresp_val first high after edge N+2, memreq_rdy low through the response cycle.
REQ-033 p_latency=0: write then read back-to-back -> each response valid one cycle after accept; num_reqs=2.
REQ-034 Hold memresp_rdy=0 for 5 cycles in RESP -> memresp_val and memresp_msg stable, memreq_rdy=0, num_reqs unchanged until handshake.
REQ-035 p_num_lines=64: write addr 0x000 then 0x400 (aliased), read 0x000 -> returns the 0x400 write data.
REQ-036 Assert reset during WAIT -> next cycle memresp_val=0, num_reqs=0, memreq_rdy=1 after deassertion.
